multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//   Main control FSM of the multi-cycle MIPS datapath. Decodes the IR opcode and
//   sequences one instruction over 3-5 cycles, driving the datapath enables and
//   the 2-bit o_aluOp consumed by the ALU-control decoder (00 add, 01 sub, 10 funct).
//   Sits between the instruction register and the datapath muxes/write enables.
// PARAMETERS
//   ENABLE_ADDI  1  1: addi (001000) supported; 0: addi treated as illegal opcode
// PORTS
//   i_clk         in   1  clock, all state changes on rising edge
//   i_rst         in   1  asynchronous, active-high reset
//   i_opcode      in   6  IR[31:26], valid from DECODE onward
//   o_pcWrite     out  1  unconditional PC write
//   o_pcWriteCond out  1  PC write if ALU zero (beq)
//   o_iorD        out  1  memory address: 0 PC, 1 ALUOut
//   o_memRead     out  1  memory read strobe
//   o_memWrite    out  1  memory write strobe
//   o_irWrite     out  1  instruction register load
//   o_memToReg    out  1  reg write data: 0 ALUOut, 1 MDR
//   o_regDst      out  1  dest reg: 0 rt, 1 rd
//   o_regWrite    out  1  register file write
//   o_aluSrcA     out  1  ALU A: 0 PC, 1 reg A
//   o_aluSrcB     out  2  ALU B: 00 reg B, 01 const 4, 10 signext imm, 11 imm<<2
//   o_aluOp       out  2  to ALU control: 00 add, 01 sub, 10 funct; 11 never driven
//   o_pcSource    out  2  PC src: 00 ALU result, 01 ALUOut, 10 jump target
//   o_illegal     out  1  high in DECODE cycle when opcode unsupported
//   o_state       out  4  current state encoding (debug)
// BEHAVIOUR
//   - State reg 4 bits: 0 FETCH,1 DECODE,2 MEMADR,3 MEMRD,4 MEMWB,5 MEMWR,6 EXEC,
//     7 ALUWB,8 BRANCH,9 ADDIEX,10 ADDIWB,11 JUMP; codes 12-15 -> FETCH next cycle.
//   - Reset: i_rst high asynchronously forces state=FETCH; while i_rst high every
//     output (incl. o_state) is 0. First cycle after release is FETCH.
//   - Outputs: Moore, combinational from state; any signal not listed below = 0.
//     FETCH : memRead,irWrite,pcWrite=1; aluSrcA=0; aluSrcB=01; aluOp=00; pcSource=00
//     DECODE: aluSrcA=0; aluSrcB=11; aluOp=00 (branch target precompute)
//     MEMADR: aluSrcA=1; aluSrcB=10; aluOp=00
//     MEMRD : iorD=1; memRead=1          MEMWR : iorD=1; memWrite=1
//     MEMWB : regDst=0; memToReg=1; regWrite=1
//     EXEC  : aluSrcA=1; aluSrcB=00; aluOp=10
//     ALUWB : regDst=1; memToReg=0; regWrite=1
//     BRANCH: aluSrcA=1; aluSrcB=00; aluOp=01; pcSource=01; pcWriteCond=1
//     ADDIEX: aluSrcA=1; aluSrcB=10; aluOp=00
//     ADDIWB: regDst=0; memToReg=0; regWrite=1
//     JUMP  : pcSource=10; pcWrite=1
//   - Transitions: FETCH->DECODE always. DECODE by i_opcode: 100011/101011->MEMADR;
//     000000->EXEC; 000100->BRANCH; 000010->JUMP; 001000->ADDIEX (ENABLE_ADDI=1);
//     else ->FETCH with o_illegal=1. MEMADR: lw->MEMRD, sw->MEMWR (i_opcode re-read,
//     IR stable). MEMRD->MEMWB. EXEC->ALUWB. ADDIEX->ADDIWB. MEMWB, MEMWR, ALUWB,
//     ADDIWB, BRANCH, JUMP ->FETCH.
//   - Latency (cycles incl. FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//   - i_opcode ignored in all states except DECODE and MEMADR.
//   - Reset asserted mid-instruction: state aborts to FETCH; no partial write
//     strobe may be asserted during or after reset until FETCH is re-entered.
// TESTING
//   - Reset then opcode 100011 -> states 0,1,2,3,4,0; MEMRD iorD=1,memRead=1;
//     MEMWB regWrite=1,memToReg=1,regDst=0.
//   - Opcode 000000 -> 0,1,6,7,0; EXEC aluOp=10,aluSrcA=1,aluSrcB=00; ALUWB regDst=1.
//   - Opcode 000100 -> 0,1,8,0; BRANCH aluOp=01,pcWriteCond=1,pcSource=01, pcWrite=0.
//   - Opcode 101011 then 000010 back-to-back -> 0,1,2,5,0,1,11,0; JUMP pcSource=10.
//   - Opcode 111111 (and 001000 with ENABLE_ADDI=0) -> DECODE o_illegal=1, next FETCH.
//   - Assert i_rst async in MEMWR -> outputs 0 immediately, no memWrite; release -> FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: decodes the IR opcode and
// sequences one instruction over 3-5 cycles with Moore datapath controls.
module multicycle_control #(
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_t state;
  state_t state_next;

  logic       pc_write;
  logic       pc_write_cond;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    illegal    = 1'b0;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI: begin
            if (ENABLE_ADDI) begin
              state_next = ADDIEX;
            end else begin
              state_next = FETCH;
              illegal    = 1'b1;
            end
          end
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      // IR is stable here, so the opcode is re-read to pick load vs store
      MEMADR: begin
        if (i_opcode == OP_LW) begin
          state_next = MEMRD;
        end else if (i_opcode == OP_SW) begin
          state_next = MEMWR;
        end else begin
          state_next = FETCH;
        end
      end
      MEMRD:   state_next = MEMWB;
      EXEC:    state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      DECODE: alu_src_b = SRCB_IMMSH;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every output so no strobe escapes while the FSM sits in FETCH
  always_comb begin
    if (i_rst) begin
      o_pcWrite     = 1'b0;
      o_pcWriteCond = 1'b0;
      o_iorD        = 1'b0;
      o_memRead     = 1'b0;
      o_memWrite    = 1'b0;
      o_irWrite     = 1'b0;
      o_memToReg    = 1'b0;
      o_regDst      = 1'b0;
      o_regWrite    = 1'b0;
      o_aluSrcA     = 1'b0;
      o_aluSrcB     = '0;
      o_aluOp       = '0;
      o_pcSource    = '0;
      o_illegal     = 1'b0;
      o_state       = '0;
    end else begin
      o_pcWrite     = pc_write;
      o_pcWriteCond = pc_write_cond;
      o_iorD        = ior_d;
      o_memRead     = mem_read;
      o_memWrite    = mem_write;
      o_irWrite     = ir_write;
      o_memToReg    = mem_to_reg;
      o_regDst      = reg_dst;
      o_regWrite    = reg_write;
      o_aluSrcA     = alu_src_a;
      o_aluSrcB     = alu_src_b;
      o_aluOp       = alu_op;
      o_pcSource    = pc_source;
      o_illegal     = illegal;
      o_state       = state;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked
// against a per-opcode state-sequence model and a per-state control table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic       rst_b;
  logic [5:0] opcode_b;
  logic       pw_b, pwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, illegal_b;
  logic [1:0] sb_b, op_b, ps_b;
  logic [3:0] state_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef int seq_t[$];

  always #5 clk = ~clk;

  multicycle_control #(.ENABLE_ADDI(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode),
    .o_pcWrite(pc_write), .o_pcWriteCond(pc_write_cond), .o_iorD(ior_d),
    .o_memRead(mem_read), .o_memWrite(mem_write), .o_irWrite(ir_write),
    .o_memToReg(mem_to_reg), .o_regDst(reg_dst), .o_regWrite(reg_write),
    .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_aluOp(alu_op),
    .o_pcSource(pc_source), .o_illegal(illegal), .o_state(state)
  );

  multicycle_control #(.ENABLE_ADDI(1'b0)) dut_noaddi (
    .i_clk(clk), .i_rst(rst_b), .i_opcode(opcode_b),
    .o_pcWrite(pw_b), .o_pcWriteCond(pwc_b), .o_iorD(iord_b),
    .o_memRead(mr_b), .o_memWrite(mw_b), .o_irWrite(irw_b),
    .o_memToReg(m2r_b), .o_regDst(rd_b), .o_regWrite(rw_b),
    .o_aluSrcA(sa_b), .o_aluSrcB(sb_b), .o_aluOp(op_b),
    .o_pcSource(ps_b), .o_illegal(illegal_b), .o_state(state_b)
  );

  logic [15:0] outs;
  assign outs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Expected control word per state, straight from the control table
  function automatic logic [15:0] exp_outs(input int s);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; pw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input bit addi_en);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b000010 || (addi_en && op == 6'b001000);
  endfunction

  function automatic seq_t seq_of(input logic [5:0] op, input bit addi_en);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b000100: return '{0, 1, 8};
      6'b000010: return '{0, 1, 11};
      6'b001000: if (addi_en) return '{0, 1, 9, 10};
      default: ;
    endcase
    return '{0, 1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Runs the first n cycles of an instruction; opcode only valid where it is read
  task automatic run_partial(input logic [5:0] op, input int n);
    seq_t q;
    q = seq_of(op, 1'b1);
    for (int k = 0; k < n && k < q.size(); k++) begin
      #1;
      opcode = (q[k] == 1 || q[k] == 2) ? op : 6'($urandom);
      #1;
      chk($sformatf("state op=%b k=%0d", op, k), 32'(state), 32'(q[k]));
      chk($sformatf("ctrl op=%b k=%0d", op, k), 32'(outs), 32'(exp_outs(q[k])));
      chk($sformatf("illegal op=%b k=%0d", op, k), 32'(illegal),
          32'(q[k] == 1 && !is_legal(op, 1'b1)));
      @(posedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] op);
    run_partial(op, 8);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1; opcode = 6'b111111; opcode_b = 6'b001000;
    repeat (2) @(posedge clk);
    #3;
    chk("reset outs", 32'(outs), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);

    @(posedge clk);
    #1 rst_b = 1'b0;
    #1 chk("noaddi fetch", 32'(state_b), 32'd0);
    @(posedge clk);
    #2 chk("noaddi decode", 32'(state_b), 32'd1);
    chk("noaddi illegal", 32'(illegal_b), 32'd1);
    @(posedge clk);
    #2 chk("noaddi back", 32'(state_b), 32'd0);
    rst_b = 1'b1;

    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(6'b100011);
    run_instr(6'b000000);
    run_instr(6'b000100);
    run_instr(6'b101011);
    run_instr(6'b000010);
    run_instr(6'b111111);
    run_instr(6'b001000);

    run_partial(6'b101011, 3);
    #2;
    chk("memwr state", 32'(state), 32'd5);
    chk("memwr strobe", 32'(mem_write), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("abort outs", 32'(outs), 32'd0);
    chk("abort state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    chk("abort hold outs", 32'(outs), 32'd0);
    chk("abort hold memwrite", 32'(mem_write), 32'd0);
    rst = 1'b0;
    run_instr(6'b000010);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      run_instr(op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
